// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    localparam int unsigned BLOCK_BYTES   = 64;
    localparam int unsigned IDX_W         = 6;
    localparam int unsigned LEN_FIELD_IDX = 56;
    localparam logic [7:0]  PAD_BYTE      = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_WAIT,
        ST_SEND
    } state_e;

endpackage

// File: rtl/sha256_block_buf.sv
// 64x8 single-port block staging buffer: synchronous write, combinational read.
module sha256_block_buf
    import sha256_pkg::*;
(
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [7:0]       wdata_i,
    output logic [7:0]       rdata_c_o
);

    logic [7:0] mem_q [BLOCK_BYTES];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 padding front-end: stages each padded 512-bit block in a byte buffer
// and streams it to the core as 64 contiguous bytes.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             idle,
    output logic             done,
    input  logic             core_busy,
    output logic [7:0]       data,
    output logic             write_enable,
    output logic             first_block,
    output logic             last_block
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] blk_q, blk_d;
    logic [LEN_W-1:0] nblk_q, nblk_d;
    logic [63:0]      len_sh_q, len_sh_d;
    logic             pad80_q, pad80_d;

    logic             in_ready_q, in_ready_d;
    logic             idle_q, idle_d;
    logic             done_q, done_d;
    logic [7:0]       data_q, data_d;
    logic             we_q, we_d;
    logic             first_q, first_d;
    logic             last_q, last_d;

    logic             buf_we_c;
    logic [IDX_W-1:0] buf_addr_c;
    logic [7:0]       buf_wdata_c;
    logic [7:0]       buf_rdata_c;
    logic             is_final_c;
    logic             idx_last_c;

    sha256_block_buf u_buf (
        .clk_i     (clk),
        .we_i      (buf_we_c),
        .addr_i    (buf_addr_c),
        .wdata_i   (buf_wdata_c),
        .rdata_c_o (buf_rdata_c)
    );

    assign is_final_c = (blk_q == nblk_q);
    assign idx_last_c = (idx_q == IDX_W'(BLOCK_BYTES - 1));

    // Next-state, counters, buffer port and registered output values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        blk_d       = blk_q;
        nblk_d      = nblk_q;
        len_sh_d    = len_sh_q;
        pad80_d     = pad80_q;
        done_d      = 1'b0;
        data_d      = 8'h00;
        we_d        = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        buf_we_c    = 1'b0;
        buf_addr_c  = idx_q;
        buf_wdata_c = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d    = msg_len;
                    idx_d    = '0;
                    blk_d    = '0;
                    nblk_d   = LEN_W'(({1'b0, msg_len} + (LEN_W+1)'(8)) >> 6);
                    len_sh_d = 64'(msg_len) << 3;
                    pad80_d  = 1'b0;
                    state_d  = (msg_len == '0) ? ST_PAD : ST_FILL;
                end
            end

            ST_FILL: begin
                if (in_valid) begin
                    buf_we_c    = 1'b1;
                    buf_wdata_c = in_data;
                    idx_d       = idx_q + IDX_W'(1);
                    rem_d       = rem_q - LEN_W'(1);
                    // A full block takes priority: flush before padding starts.
                    if (idx_last_c) begin
                        state_d = ST_WAIT;
                    end else if (rem_q == LEN_W'(1)) begin
                        state_d = ST_PAD;
                    end
                end
            end

            ST_PAD: begin
                buf_we_c = 1'b1;
                idx_d    = idx_q + IDX_W'(1);
                if (!pad80_q) begin
                    buf_wdata_c = PAD_BYTE;
                    pad80_d     = 1'b1;
                end else if (is_final_c && (idx_q >= IDX_W'(LEN_FIELD_IDX))) begin
                    buf_wdata_c = len_sh_q[63:56];
                    len_sh_d    = len_sh_q << 8;
                end
                if (idx_last_c) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (!core_busy) begin
                    buf_addr_c = '0;
                    data_d     = buf_rdata_c;
                    we_d       = 1'b1;
                    first_d    = (blk_q == '0);
                    last_d     = is_final_c;
                    idx_d      = '0;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                idx_d = idx_q + IDX_W'(1);
                // Outputs lead the index by one so byte k is on the bus while idx_q=k.
                if (!idx_last_c) begin
                    buf_addr_c = idx_q + IDX_W'(1);
                    data_d     = buf_rdata_c;
                    we_d       = 1'b1;
                end else begin
                    blk_d = blk_q + LEN_W'(1);
                    if (is_final_c) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (rem_q != '0) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_PAD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_FILL);
        idle_d     = (state_d == ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rem_q      <= '0;
            blk_q      <= '0;
            nblk_q     <= '0;
            len_sh_q   <= '0;
            pad80_q    <= 1'b0;
            in_ready_q <= 1'b0;
            idle_q     <= 1'b1;
            done_q     <= 1'b0;
            data_q     <= 8'h00;
            we_q       <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            blk_q      <= blk_d;
            nblk_q     <= nblk_d;
            len_sh_q   <= len_sh_d;
            pad80_q    <= pad80_d;
            in_ready_q <= in_ready_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            data_q     <= data_d;
            we_q       <= we_d;
            first_q    <= first_d;
            last_q     <= last_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign idle         = idle_q;
    assign done         = done_q;
    assign data         = data_q;
    assign write_enable = we_q;
    assign first_block  = first_q;
    assign last_block   = last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: a reference SHA-256 padding model fills a
// byte scoreboard that is drained as the DUT streams blocks to the core.
module tb_sha256_padder;

    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             idle;
    logic             done;
    logic             core_busy;
    logic [7:0]       data;
    logic             write_enable;
    logic             first_block;
    logic             last_block;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] msg_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    sha256_padder #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .msg_len      (msg_len),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .idle         (idle),
        .done         (done),
        .core_busy    (core_busy),
        .data         (data),
        .write_enable (write_enable),
        .first_block  (first_block),
        .last_block   (last_block)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_idle"}, 64'(idle), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_data"}, 64'(data), 64'd0);
        check({tag, "_we"}, 64'(write_enable), 64'd0);
        check({tag, "_flags"}, 64'({first_block, last_block}), 64'd0);
    endtask

    // kind 0: all 0x30, kind 1: random bytes, kind 2: "abc"
    task automatic set_msg(input int len, input int kind);
        msg_q.delete();
        for (int i = 0; i < len; i++) begin
            if (kind == 2)      msg_q.push_back(8'h61 + 8'(i));
            else if (kind == 1) msg_q.push_back(8'($urandom_range(0, 255)));
            else                msg_q.push_back(8'h30);
        end
    endtask

    // Reference padding: message, 0x80, zeros, 64-bit big-endian bit length.
    task automatic build_expected(input int len);
        exp_t        e;
        int          total;
        logic [63:0] bitlen;
        total  = ((len + 8) / 64 + 1) * 64;
        bitlen = 64'(len) * 64'd8;
        exp_q.delete();
        for (int i = 0; i < total; i++) begin
            if (i < len)       e.data = msg_q[i];
            else if (i == len) e.data = 8'h80;
            else               e.data = 8'h00;
            if (i >= total - 8) e.data = bitlen[8*(total-1-i) +: 8];
            e.first = (i == 0);
            e.last  = (i == total - 64);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_msg(input int len, input int busy_hold, input bit toggle,
                           input int stray_cyc, input int abort_at);
        exp_t e;
        int   cyc, in_idx, run, sent, first_we, limit;
        bit   done_seen;
        build_expected(len);
        limit = 400 * ((len + 8) / 64 + 1) + busy_hold + 200;
        @(negedge clk);
        start     = 1'b1;
        msg_len   = LEN_W'(len);
        core_busy = (busy_hold > 0);
        cyc = 0; in_idx = 0; run = 0; sent = 0; first_we = -1; done_seen = 0;
        while (!done_seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (write_enable) begin
                if (first_we < 0) first_we = cyc;
                run++;
                sent++;
                if (exp_q.size() == 0) begin
                    check("extra_byte", 64'(sent), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", sent - 1),
                          64'({data, first_block, last_block}),
                          64'({e.data, e.first, e.last}));
                end
                if (abort_at >= 0 && sent == abort_at + 1) begin
                    reset = 1'b1;
                    #1;
                    check_reset_outputs("abort");
                    @(negedge clk);
                    reset    = 1'b0;
                    start    = 1'b0;
                    in_valid = 1'b0;
                    exp_q.delete();
                    return;
                end
            end else if (run != 0) begin
                check("block_len", 64'(run), 64'd64);
                run = 0;
            end
            if (done) begin
                done_seen = 1;
                check("done_idle", 64'({idle, write_enable}), 64'b10);
                check("queue_empty", 64'(exp_q.size()), 64'd0);
            end
            start     = (cyc == stray_cyc);
            msg_len   = LEN_W'(5);
            core_busy = (cyc < busy_hold);
            in_valid  = toggle ? cyc[0] : 1'b1;
            in_data   = (in_idx < len) ? msg_q[in_idx] : 8'hEE;
            if (in_valid && in_ready) in_idx++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("done_seen", 64'(done_seen), 64'd1);
        check("accepted", 64'(in_idx), 64'(len));
        if (busy_hold > 0) check("send_after_busy", 64'(first_we), 64'(busy_hold + 1));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        msg_len   = '0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        core_busy = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        set_msg(3, 2);    run_msg(3, 0, 0, -1, -1);
        set_msg(56, 0);   run_msg(56, 0, 0, -1, -1);
        set_msg(120, 0);  run_msg(120, 0, 0, 5, -1);
        set_msg(55, 1);   run_msg(55, 0, 0, -1, -1);
        set_msg(64, 1);   run_msg(64, 0, 0, -1, -1);
        set_msg(0, 0);    run_msg(0, 0, 0, -1, -1);
        set_msg(3, 2);    run_msg(3, 200, 0, -1, -1);
        set_msg(70, 1);   run_msg(70, 0, 1, -1, -1);
        set_msg(120, 1);  run_msg(120, 0, 0, -1, 30);
        set_msg(3, 2);    run_msg(3, 0, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
